// File: rtl/darkbus_arbiter_if.sv
// Handshake bundle for one darkbus port: a requester drives the request side,
// a responder returns data, acknowledges and the timeout error.
interface darkbus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              en;
    logic              re;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rack;
    logic              wack;
    logic              err;

    modport master (output en, re, we, be, addr, wdata,
                    input  rdata, rack, wack, err);
    modport slave  (input  en, re, we, be, addr, wdata,
                    output rdata, rack, wack, err);
endinterface

// File: rtl/darkbus_arbiter.sv
// Round-robin arbiter sharing one darkbus memory port between instruction
// fetch (m0) and load/store (m1), with a per-transaction timeout.
module darkbus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             XCLK,
    input  logic             XRES,
    darkbus_arbiter_if.slave m0,
    darkbus_arbiter_if.slave m1,
    darkbus_arbiter_if.master s,
    output logic [1:0]       GNT
);
    localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t  state;
    logic    last;
    logic [CW-1:0] cnt;

    logic [1:0]             m_en, m_re, m_we;
    logic [1:0][3:0]        m_be;
    logic [1:0][ADDR_W-1:0] m_addr;
    logic [1:0][DATA_W-1:0] m_wdata;

    assign m_en    = {m1.en, m0.en};
    assign m_re    = {m1.re, m0.re};
    assign m_we    = {m1.we, m0.we};
    assign m_be    = {m1.be, m0.be};
    assign m_addr  = {m1.addr, m0.addr};
    assign m_wdata = {m1.wdata, m0.wdata};

    logic sel, granted, drive, wr, rd, ack, tmo, done;

    assign sel     = (state == GRANT1);
    assign granted = (state != IDLE);
    assign drive   = granted & m_en[sel];
    // RE+WE together is a write; the read strobe is suppressed.
    assign wr      = drive & m_we[sel];
    assign rd      = drive & m_re[sel] & ~m_we[sel];
    assign ack     = (wr & s.wack) | (rd & s.rack);
    assign tmo     = TMO_EN && drive && !ack && (cnt == CW'(TIMEOUT));
    assign done    = ack | tmo;

    assign s.en    = drive & ~tmo;
    assign s.re    = rd;
    assign s.we    = wr;
    assign s.be    = drive ? m_be[sel]    : '0;
    assign s.addr  = drive ? m_addr[sel]  : '0;
    assign s.wdata = drive ? m_wdata[sel] : '0;

    logic [1:0]             rack_v, wack_v, err_v;
    logic [1:0][DATA_W-1:0] rdata_v;

    for (genvar i = 0; i < 2; i++) begin : g_ret
        logic own;
        assign own        = granted & (sel == 1'(i));
        assign rack_v[i]  = own & rd & done;
        assign wack_v[i]  = own & wr & done;
        assign err_v[i]   = own & tmo;
        assign rdata_v[i] = (rack_v[i] & ~tmo) ? s.rdata : '0;
    end

    assign m0.rack  = rack_v[0];
    assign m0.wack  = wack_v[0];
    assign m0.err   = err_v[0];
    assign m0.rdata = rdata_v[0];
    assign m1.rack  = rack_v[1];
    assign m1.wack  = wack_v[1];
    assign m1.err   = err_v[1];
    assign m1.rdata = rdata_v[1];

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
            GNT   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // On contention the master that did not finish last wins.
                    if (m_en[0] && (!m_en[1] || last)) begin
                        state <= GRANT0;
                        GNT   <= 2'b01;
                    end else if (m_en[1]) begin
                        state <= GRANT1;
                        GNT   <= 2'b10;
                    end
                end
                default: begin
                    if (!drive) begin
                        state <= IDLE;
                        GNT   <= 2'b00;
                        cnt   <= '0;
                    end else if (done) begin
                        state <= IDLE;
                        GNT   <= 2'b00;
                        last  <= sel;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_darkbus_arbiter.sv
// Directed bench for darkbus_arbiter: a small latency-programmable slave model
// and cycle-exact expectations for each scenario.
module tb_darkbus_arbiter;
    logic XCLK = 1'b0;
    logic XRES;
    always #5 XCLK = ~XCLK;

    darkbus_arbiter_if m0_if ();
    darkbus_arbiter_if m1_if ();
    darkbus_arbiter_if s_if ();
    logic [1:0] gnt;

    darkbus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .XCLK (XCLK),
        .XRES (XRES),
        .m0   (m0_if),
        .m1   (m1_if),
        .s    (s_if),
        .GNT  (gnt)
    );

    // Slave acknowledges in the slv_lat-th consecutive S_EN cycle.
    int   slv_lat;
    logic slv_on, stray_rack, slv_hit;
    int   scnt = 0;
    always @(posedge XCLK) scnt <= (XRES || !s_if.en) ? 0 : scnt + 1;
    assign slv_hit     = slv_on && s_if.en && (scnt == slv_lat - 1);
    assign s_if.rack   = (slv_hit && s_if.re) || stray_rack;
    assign s_if.wack   = slv_hit && s_if.we;
    assign s_if.rdata  = s_if.rack ? 32'h12345678 : 32'hDEADBEEF;
    assign s_if.err    = 1'b0;

    int ack0 = 0, ack1 = 0;
    always @(posedge XCLK) begin
        if (!XRES) begin
            ack0 <= ack0 + int'(m0_if.rack | m0_if.wack);
            ack1 <= ack1 + int'(m1_if.rack | m1_if.wack);
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    task automatic drv(input int m, input logic en, input logic re, input logic we,
                       input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_if.en = en; m0_if.re = re; m0_if.we = we;
            m0_if.be = be; m0_if.addr = addr; m0_if.wdata = wdata;
        end else begin
            m1_if.en = en; m1_if.re = re; m1_if.we = we;
            m1_if.be = be; m1_if.addr = addr; m1_if.wdata = wdata;
        end
    endtask

    task automatic nxt();
        @(posedge XCLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int a0, a1;
        logic [1:0] arb_exp [8];
        arb_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

        XRES = 1'b1; slv_lat = 2; slv_on = 1'b1; stray_rack = 1'b0;
        drv(0, 0, 0, 0, 4'h0, 0, 0);
        drv(1, 0, 0, 0, 4'h0, 0, 0);
        nxt(); nxt();
        @(negedge XCLK);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_sen", 32'({s_if.en, s_if.re, s_if.we, s_if.be}), 0);
        chk("rst_m0rdata", m0_if.rdata, 0);
        chk("rst_m1resp", 32'({m1_if.rack, m1_if.wack, m1_if.err}), 0);

        // single read by m0, slave latency 2
        nxt(); XRES = 1'b0; drv(0, 1, 1, 0, 4'hF, 32'h10, 0);
        @(negedge XCLK); chk("rd_idle_sen", 32'(s_if.en), 0);
        nxt(); @(negedge XCLK);
        chk("rd_c1_sen", 32'(s_if.en), 1);
        chk("rd_c1_gnt", 32'(gnt), 1);
        chk("rd_c1_addr", s_if.addr, 32'h10);
        chk("rd_c1_rack", 32'(m0_if.rack), 0);
        nxt(); @(negedge XCLK);
        chk("rd_c2_sen", 32'(s_if.en), 1);
        chk("rd_c2_rack", 32'(m0_if.rack), 1);
        chk("rd_c2_rdata", m0_if.rdata, 32'h12345678);
        nxt(); drv(0, 0, 0, 0, 4'h0, 0, 0);
        @(negedge XCLK);
        chk("rd_turn_gnt", 32'(gnt), 0);
        chk("rd_turn_sen", 32'(s_if.en), 0);
        chk("rd_turn_rdata", m0_if.rdata, 0);
        nxt(); @(negedge XCLK);
        chk("rd_ack0_cnt", 32'(ack0), 1);

        // m1 write with partial byte enables
        slv_lat = 1;
        nxt(); drv(1, 1, 0, 1, 4'b0011, 32'h1004, 32'hA5A5A5A5);
        nxt(); @(negedge XCLK);
        chk("wr_gnt", 32'(gnt), 2);
        chk("wr_swe", 32'({s_if.we, s_if.re}), 32'b10);
        chk("wr_sbe", 32'(s_if.be), 32'b0011);
        chk("wr_addr", s_if.addr, 32'h1004);
        chk("wr_wdata", s_if.wdata, 32'hA5A5A5A5);
        chk("wr_m1resp", 32'({m1_if.wack, m1_if.rack}), 32'b10);
        nxt(); drv(1, 0, 0, 0, 4'h0, 0, 0);
        @(negedge XCLK); chk("wr_idle_gnt", 32'(gnt), 0);

        // contention: both request continuously, m1 finished last
        nxt(); drv(0, 1, 1, 0, 4'hF, 32'h100, 0); drv(1, 1, 1, 0, 4'hF, 32'h200, 0);
        a0 = ack0; a1 = ack1;
        for (int i = 0; i < 8; i++) begin
            nxt(); @(negedge XCLK);
            chk($sformatf("arb_gnt%0d", i), 32'(gnt), 32'(arb_exp[i]));
        end
        nxt(); drv(0, 0, 0, 0, 4'h0, 0, 0); drv(1, 0, 0, 0, 4'h0, 0, 0);
        nxt(); nxt(); @(negedge XCLK);
        chk("arb_ack0", 32'(ack0 - a0), 2);
        chk("arb_ack1", 32'(ack1 - a1), 2);

        // timeout on m0 read with m1 write pending
        slv_on = 1'b0;
        nxt(); drv(0, 1, 1, 0, 4'hF, 32'h20, 0); drv(1, 1, 0, 1, 4'hF, 32'h30, 32'h55);
        for (int i = 1; i <= 4; i++) begin
            nxt(); @(negedge XCLK);
            chk($sformatf("tmo_c%0d_sen", i), 32'(s_if.en), 1);
            chk($sformatf("tmo_c%0d_rack", i), 32'(m0_if.rack), 0);
        end
        nxt(); @(negedge XCLK);
        chk("tmo_c5_sen", 32'(s_if.en), 0);
        chk("tmo_c5_m0resp", 32'({m0_if.rack, m0_if.err, m0_if.wack}), 32'b110);
        chk("tmo_c5_rdata", m0_if.rdata, 0);
        chk("tmo_c5_m1err", 32'(m1_if.err), 0);
        nxt(); drv(0, 0, 0, 0, 4'h0, 0, 0); slv_on = 1'b1;
        @(negedge XCLK); chk("tmo_idle_gnt", 32'(gnt), 0);
        nxt(); @(negedge XCLK);
        chk("tmo_m1_gnt", 32'(gnt), 2);
        chk("tmo_m1_resp", 32'({m1_if.wack, m1_if.err}), 32'b10);
        nxt(); drv(1, 0, 0, 0, 4'h0, 0, 0);

        // abort in 2nd granted cycle, then stray RACK in IDLE
        slv_lat = 3;
        nxt(); drv(1, 1, 1, 0, 4'hF, 32'h40, 0);
        nxt(); @(negedge XCLK); chk("ab_c1_sen", 32'(s_if.en), 1);
        nxt(); drv(1, 0, 0, 0, 4'h0, 0, 0);
        @(negedge XCLK);
        chk("ab_c2_sen", 32'(s_if.en), 0);
        chk("ab_c2_m1resp", 32'({m1_if.rack, m1_if.wack, m1_if.err}), 0);
        nxt(); stray_rack = 1'b1;
        @(negedge XCLK);
        chk("st_gnt", 32'(gnt), 0);
        chk("st_m0resp", 32'({m0_if.rack, m0_if.wack, m0_if.err}), 0);
        chk("st_m1resp", 32'({m1_if.rack, m1_if.wack, m1_if.err}), 0);
        chk("st_m0rdata", m0_if.rdata, 0);

        // m0 completes so the pre-reset round-robin pointer favours m1
        nxt(); stray_rack = 1'b0; slv_lat = 1; drv(0, 1, 1, 0, 4'hF, 32'h50, 0);
        nxt(); @(negedge XCLK); chk("l0_rack", 32'(m0_if.rack), 1);
        nxt(); drv(0, 0, 0, 0, 4'h0, 0, 0);

        // reset during GRANT1
        slv_on = 1'b0; drv(1, 1, 1, 0, 4'hF, 32'h60, 0);
        nxt(); @(negedge XCLK); chk("rs_g1_gnt", 32'(gnt), 2);
        nxt(); XRES = 1'b1;
        @(negedge XCLK); chk("rs_hold_gnt", 32'(gnt), 2);
        nxt(); drv(0, 1, 1, 0, 4'hF, 32'h70, 0);
        @(negedge XCLK);
        chk("rs_gnt", 32'(gnt), 0);
        chk("rs_sen", 32'({s_if.en, s_if.re, s_if.we}), 0);
        chk("rs_m1resp", 32'({m1_if.rack, m1_if.wack, m1_if.err}), 0);
        nxt(); XRES = 1'b0; slv_on = 1'b1;
        nxt(); @(negedge XCLK); chk("rs_first_gnt", 32'(gnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/darkbus_arbiter.md
Name: darkbus_arbiter

Overview:
Two-requester arbiter sharing one device_bus-style memory port between the instruction-fetch side (M0) and the data load/store side (M1) of the core. It sits between the core's bus logic and the memory map (darkmm). It does four things: grants one requester per transaction, steers that requester's signals to the slave port, routes the acknowledges back, and ends stalled transactions with a timeout. It replaces the fixed I/L/E phase sequencing with request-driven, round-robin sharing.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width.
TIMEOUT, 255, maximum cycles a granted transaction may wait for RACK/WACK before an error completion; 0 disables the timeout.

Ports:
XCLK  in  1  system clock.
XRES  in  1  reset, synchronous, active-high.
M0_EN, M1_EN  in  1  request valid, one per master.
M0_RE, M1_RE  in  1  read request.
M0_WE, M1_WE  in  1  write request.
M0_BE, M1_BE  in  4  byte enables.
M0_ADDR, M1_ADDR  in  ADDR_W  address.
M0_WDATA, M1_WDATA  in  DATA_W  write data.
M0_RDATA, M1_RDATA  out  DATA_W  read data.
M0_RACK, M1_RACK  out  1  read complete, 1-cycle pulse.
M0_WACK, M1_WACK  out  1  write complete, 1-cycle pulse.
M0_ERR, M1_ERR  out  1  timeout completion, pulses with the matching ACK.
S_EN, S_RE, S_WE  out  1  slave control.
S_BE  out  4  slave byte enables.
S_ADDR  out  ADDR_W  slave address.
S_WDATA  out  DATA_W  slave write data.
S_RDATA  in  DATA_W  slave read data.
S_RACK, S_WACK  in  1  slave acknowledges.
GNT  out  2  one-hot current grant, for debug.

Behaviour:
- Clocking and reset: one clock, XCLK. Reset XRES is synchronous and active-high.
- States: IDLE, GRANT0, GRANT1. Reset forces IDLE, LAST=1, timeout counter=0.
- Reset values of outputs: GNT=00; all S_* outputs 0; all M*_RACK, M*_WACK and M*_ERR 0; M*_RDATA 0.
- IDLE: samples M0_EN and M1_EN.
  - Only one EN high: that master's GRANT state next cycle.
  - Both high: the master other than LAST is granted.
  - Neither high: stay in IDLE.
- Grant latency: EN sampled in IDLE at cycle N gives S_EN=1 in cycle N+1.
- GRANTx steering:
  - S_EN, S_RE, S_WE, S_BE, S_ADDR and S_WDATA are driven combinationally from master x.
  - The other master sees ACK=0 and ERR=0.
  - RE and WE both high: treated as a write. S_RE=0, completion on S_WACK only.
- Completion:
  - Write: S_WACK=1 while S_WE=1.
  - Read: S_RACK=1 while S_RE=1.
  - The matching Mx_RACK or Mx_WACK is asserted combinationally in the same cycle; Mx_RDATA = S_RDATA.
  - Next state is IDLE, and LAST is set to x.
- Turnaround: there is always one IDLE cycle between transactions. Worst-case access time is 1 grant cycle + slave latency + 1 idle cycle.
- Abort: master drops Mx_EN while granted.
  - S_EN drops in the same cycle; next state is IDLE.
  - No ACK and no ERR are given; LAST is unchanged.
- Timeout:
  - The counter increments each granted cycle without an acknowledge.
  - When it reaches TIMEOUT, Mx_ERR=1 and Mx_RACK or Mx_WACK=1 for one cycle, with Mx_RDATA=0. S_EN=0 in that cycle.
  - Next state is IDLE; LAST=x; the counter clears.
  - An acknowledge in the same cycle that TIMEOUT is reached takes priority: normal completion, ERR=0.
- Unrequested slave acknowledges: S_RACK or S_WACK arriving in IDLE are ignored.
- Mx_RDATA holds 0 whenever the matching RACK is 0.
- Masters must keep ADDR, BE, WDATA, RE and WE stable while EN=1 until their ACK. Behaviour otherwise is undefined, but the arbiter must not lock up.
- Reset mid-transaction: XRES takes effect at the next edge. All outputs return to reset values, and no ACK is produced for the aborted transaction.

Test Plan:
- Single read: M0 reads 0x00000010 with slave RACK 2 cycles after S_EN. Required: S_EN high 2 cycles; M0_RACK pulses once with RDATA=0x12345678; GNT returns to 00 for 1 cycle.
- Contention: M0 and M1 requesting continuously from reset. Required: grant order is M0, M1, M0, M1, with exactly one IDLE cycle between grants and no double acknowledge.
- Write with byte enables: M1 writes 0xA5A5A5A5 to 0x00001004 with BE=0011. Required: the slave sees S_WE=1, S_BE=0011 and the data; M1_WACK pulses; M1_RACK stays 0.
- Timeout: TIMEOUT=4 and the slave never acknowledges an M0 read. Required: M0_RACK=1, M0_ERR=1 and RDATA=0 in the 5th granted cycle; the next pending M1 request is granted after 1 IDLE cycle.
- Abort and unrequested acknowledge: M1 drops EN in its 2nd granted cycle. Required: S_EN=0 the same cycle and no M1 ACK. A stray S_RACK in IDLE produces no ACK on either master.
- Reset mid-transaction: XRES=1 during GRANT1. Required: all outputs are 0 at the next edge; after release with both masters requesting, M0 is granted first (LAST=1).
